aq_mmu_jtlb_tag_ctrl: RTL and testbench
=======================================

AQ_MMU_JTLB_TAG_CTRL -- requirements
Module: aq_mmu_jtlb_tag_ctrl

Interface
REQ-001 SHALL have port forever_cpuclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port cpurst_b, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port lkup_req_vld, input, 1 bit: lookup read request.
REQ-004 SHALL have port lkup_idx, input, 6 bits: lookup set index.
REQ-005 SHALL have port lkup_req_rdy, output, 1 bit: lookup accepted this cycle when high together with lkup_req_vld.
REQ-006 SHALL have port lkup_rsp_vld, output, 1 bit: lookup data valid.
REQ-007 SHALL have port lkup_rsp_tag, output, 98 bits: {fifo[1:0], way1[47:0], way0[47:0]}.
REQ-008 SHALL have port lkup_rsp_victim, output, 1 bit: victim way for refill, equal to fifo bit 0.
REQ-009 SHALL have port wr_req_vld, input, 1 bit: refill write request.
REQ-010 SHALL have port wr_idx, input, 6 bits: refill write set index.
REQ-011 SHALL have port wr_way, input, 1 bit: refill target way.
REQ-012 SHALL have port wr_tag, input, 48 bits: refill tag entry.
REQ-013 SHALL have port wr_req_rdy, output, 1 bit: write accepted when high together with wr_req_vld.
REQ-014 SHALL have port inv_all_req, input, 1 bit: start invalidate-all sweep.
REQ-015 SHALL have port inv_busy, output, 1 bit: sweep in progress.
REQ-016 SHALL have port inv_done, output, 1 bit: one-cycle pulse at sweep end.
REQ-017 SHALL have SRAM-side outputs jtlb_tag_cen (1), jtlb_tag_wen (3: fifo, way1, way0), jtlb_tag_idx (9), jtlb_tag_din (98), and input jtlb_tag_dout (98).

Function
REQ-018 SHALL implement FSM states IDLE, INV, DONE.
REQ-019 SHALL arbitrate in priority order INV sweep > write > lookup, with at most one SRAM access per cycle.
REQ-020 SHALL drive jtlb_tag_idx[8:6] to 0 at all times.
REQ-021 SHALL, in IDLE on an accepted lookup, drive cen=1 and wen=3'b000 with idx=lkup_idx.
REQ-022 SHALL pulse lkup_rsp_vld exactly one cycle after lookup acceptance, with lkup_rsp_tag=jtlb_tag_dout in that cycle.
REQ-023 SHALL, in IDLE on an accepted write, drive cen=1, wen[2]=1, wen[wr_way]=1 and wen[~wr_way]=0.
REQ-024 SHALL drive din={1'b0, ~wr_way, wr_tag, wr_tag} on a write, so the written way is not next victim.
REQ-025 SHALL set wr_req_rdy=1 only in IDLE.
REQ-026 SHALL set lkup_req_rdy=1 only in IDLE with wr_req_vld=0; simultaneous write+lookup means the write wins and the lookup stalls.
REQ-027 SHALL move from IDLE to INV on inv_all_req=1, taking priority over pending write and lookup that cycle.
REQ-028 SHALL, in INV, drive cen=1, wen=3'b111, din=0, idx=6-bit sweep counter, with the counter incrementing each cycle from 0.
REQ-029 SHALL go INV->DONE after writing index 63 (64 write cycles), then DONE->IDLE after one cycle, with inv_done=1 in DONE only.
REQ-030 SHALL hold inv_busy=1 in INV and DONE, and ignore inv_all_req while busy.
REQ-031 SHALL drive cen=0, wen=0 and din=0 when no access is issued.
REQ-032 SHALL never assert lkup_rsp_vld in the cycle after a non-read access.

Reset
REQ-033 SHALL, on cpurst_b=0 at a clock edge, set state=IDLE, sweep counter=0, and lkup_rsp_vld=inv_done=inv_busy=0.
REQ-034 SHALL, during reset, drive cen=0, wen=0, lkup_req_rdy=0 and wr_req_rdy=0.
REQ-035 SHALL, on reset mid-sweep, abort the sweep with no inv_done pulse.
REQ-036 SHALL, on reset the cycle after lookup acceptance, suppress lkup_rsp_vld.

Configuration
REQ-037 SHALL, with JTLB_INV_ON_RST_EN defined, enter INV automatically in the first cycle after cpurst_b rises and complete a full sweep with an inv_done pulse.
REQ-038 SHALL, with JTLB_INV_ON_RST_EN undefined, remain in IDLE after reset until inv_all_req.

Verification
REQ-039 SHALL cover this scenario: lookup idx=5 in IDLE -> cen=1, wen=000, idx=9'd5; next cycle lkup_rsp_vld=1 and rsp_tag equals model dout.
REQ-040 SHALL cover this scenario: write idx=12, way=1, tag=48'hABC -> wen=3'b110, din[97:96]=2'b00; a subsequent lookup idx=12 returns victim=0 and way1=48'hABC.
REQ-041 SHALL cover this scenario: wr_req_vld and lkup_req_vld in the same cycle -> write issued, lkup_req_rdy=0; lookup accepted the next cycle.
REQ-042 SHALL cover this scenario: inv_all_req -> 64 cycles of wen=111, din=0, idx 0..63; inv_done pulses once on cycle 65 after start; all entries then read 0.
REQ-043 SHALL cover this scenario: cpurst_b low at sweep index 30 -> cen=0 next cycle, no inv_done, state IDLE (without JTLB_INV_ON_RST_EN).
REQ-044 SHALL cover this scenario: with JTLB_INV_ON_RST_EN defined, release reset -> sweep starts the next cycle and wr_req_rdy=0 until the cycle after inv_done.

Source files
------------

// File: rtl/aq_mmu_jtlb_tag_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : aq_mmu_jtlb_tag_ctrl_if
// Purpose  : Bundles the signals of the JTLB tag controller.
//            - lookup request/response
//            - refill write request
//            - invalidate-all control
//            - tag SRAM port
// Revision : 1.0 - initial release
// ============================================================================
interface aq_mmu_jtlb_tag_ctrl_if;
    // Lookup channel
    logic        lkup_req_vld;
    logic [5:0]  lkup_idx;
    logic        lkup_req_rdy;
    logic        lkup_rsp_vld;
    logic [97:0] lkup_rsp_tag;
    logic        lkup_rsp_victim;

    // Refill write channel
    logic        wr_req_vld;
    logic [5:0]  wr_idx;
    logic        wr_way;
    logic [47:0] wr_tag;
    logic        wr_req_rdy;

    // Invalidate-all control
    logic        inv_all_req;
    logic        inv_busy;
    logic        inv_done;

    // Tag SRAM port: wen bits are {fifo, way1, way0}
    logic        jtlb_tag_cen;
    logic [2:0]  jtlb_tag_wen;
    logic [8:0]  jtlb_tag_idx;
    logic [97:0] jtlb_tag_din;
    logic [97:0] jtlb_tag_dout;

    // Controller side
    modport slave (
        input  lkup_req_vld, lkup_idx, wr_req_vld, wr_idx, wr_way, wr_tag,
               inv_all_req, jtlb_tag_dout,
        output lkup_req_rdy, lkup_rsp_vld, lkup_rsp_tag, lkup_rsp_victim,
               wr_req_rdy, inv_busy, inv_done,
               jtlb_tag_cen, jtlb_tag_wen, jtlb_tag_idx, jtlb_tag_din
    );

    // Requester / SRAM side
    modport master (
        output lkup_req_vld, lkup_idx, wr_req_vld, wr_idx, wr_way, wr_tag,
               inv_all_req, jtlb_tag_dout,
        input  lkup_req_rdy, lkup_rsp_vld, lkup_rsp_tag, lkup_rsp_victim,
               wr_req_rdy, inv_busy, inv_done,
               jtlb_tag_cen, jtlb_tag_wen, jtlb_tag_idx, jtlb_tag_din
    );
endinterface
`default_nettype wire

// File: rtl/aq_mmu_jtlb_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aq_mmu_jtlb_tag_ctrl
// Purpose  : JTLB tag SRAM access controller.
//            - Arbitrates between an invalidate-all sweep, refill writes and
//              lookup reads.
//            - Issues at most one SRAM access per cycle.
// Options  : JTLB_INV_ON_RST_EN - run a full invalidate sweep right after reset
// Revision : 1.0 - initial release
// ============================================================================
module aq_mmu_jtlb_tag_ctrl (
    input  wire logic              forever_cpuclk,
    input  wire logic              cpurst_b,
    aq_mmu_jtlb_tag_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

`ifdef JTLB_INV_ON_RST_EN
    localparam state_e RST_STATE = ST_INV;
`else
    localparam state_e RST_STATE = ST_IDLE;
`endif

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        rsp_vld_q, rsp_vld_d;

    logic        cen;
    logic [2:0]  wen;
    logic [5:0]  idx;
    logic [97:0] din;
    logic        wr_rdy;
    logic        lk_rdy;
    logic        busy;
    logic        done;

    // Next-state, arbitration and SRAM command generation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rsp_vld_d = 1'b0;
        cen       = 1'b0;
        wen       = 3'b000;
        idx       = 6'd0;
        din       = '0;
        wr_rdy    = 1'b0;
        lk_rdy    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.inv_all_req) begin
                    // Sweep request wins; nothing else is accepted this cycle
                    state_d = ST_INV;
                    cnt_d   = 6'd0;
                end else begin
                    wr_rdy = 1'b1;
                    lk_rdy = ~bus.wr_req_vld;
                    if (bus.wr_req_vld) begin
                        // The refilled way becomes the most recent, so the
                        // other way is the next victim.
                        cen = 1'b1;
                        wen = {1'b1, bus.wr_way, ~bus.wr_way};
                        idx = bus.wr_idx;
                        din = {1'b0, ~bus.wr_way, bus.wr_tag, bus.wr_tag};
                    end else if (bus.lkup_req_vld) begin
                        cen       = 1'b1;
                        idx       = bus.lkup_idx;
                        rsp_vld_d = 1'b1;
                    end
                end
            end
            ST_INV: begin
                busy  = 1'b1;
                cen   = 1'b1;
                wen   = 3'b111;
                idx   = cnt_q;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // While reset is held nothing may reach the SRAM or the requesters
        if (!cpurst_b) begin
            rsp_vld_d = 1'b0;
            cen       = 1'b0;
            wen       = 3'b000;
            idx       = 6'd0;
            din       = '0;
            wr_rdy    = 1'b0;
            lk_rdy    = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

    // State, sweep counter and lookup-response registers
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q   <= RST_STATE;
            cnt_q     <= 6'd0;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign bus.jtlb_tag_cen    = cen;
    assign bus.jtlb_tag_wen    = wen;
    assign bus.jtlb_tag_idx    = {3'b000, idx};
    assign bus.jtlb_tag_din    = din;
    assign bus.wr_req_rdy      = wr_rdy;
    assign bus.lkup_req_rdy    = lk_rdy;
    assign bus.inv_busy        = busy;
    assign bus.inv_done        = done;
    // SRAM read data arrives one cycle after the read; the response is dropped
    // if reset lands in that cycle.
    assign bus.lkup_rsp_vld    = rsp_vld_q & cpurst_b;
    assign bus.lkup_rsp_tag    = bus.jtlb_tag_dout;
    assign bus.lkup_rsp_victim = bus.jtlb_tag_dout[96];

endmodule
`default_nettype wire

// File: tb/tb_aq_mmu_jtlb_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aq_mmu_jtlb_tag_ctrl
// Purpose  : Self-checking bench for aq_mmu_jtlb_tag_ctrl.
//            - Behavioural tag SRAM.
//            - Array reference model of the expected tag contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aq_mmu_jtlb_tag_ctrl;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    aq_mmu_jtlb_tag_ctrl_if bus ();

    aq_mmu_jtlb_tag_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .bus            (bus)
    );

    logic [97:0] sram    [64];
    logic [97:0] ref_mem [64];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [97:0] init_row(input int i);
        return {2'(i), 48'h5A5A_0000_0000 + 48'(i), 48'hC3C3_0000_0000 ^ 48'(i)};
    endfunction

    // Expected row contents after a refill: the other way becomes the victim
    function automatic void ref_write(input logic [5:0] i, input logic w, input logic [47:0] t);
        ref_mem[i][97:96] = {1'b0, ~w};
        if (w) ref_mem[i][95:48] = t;
        else   ref_mem[i][47:0]  = t;
    endfunction

    // Tag SRAM: one-cycle read latency, per-field write enables
    initial begin
        for (int i = 0; i < 64; i++) sram[i] = init_row(i);
        bus.jtlb_tag_dout = '0;
        forever begin
            @(posedge clk);
            if (bus.jtlb_tag_cen) begin
                if (bus.jtlb_tag_wen == 3'b000) begin
                    bus.jtlb_tag_dout <= sram[bus.jtlb_tag_idx[5:0]];
                end else begin
                    if (bus.jtlb_tag_wen[2]) sram[bus.jtlb_tag_idx[5:0]][97:96] = bus.jtlb_tag_din[97:96];
                    if (bus.jtlb_tag_wen[1]) sram[bus.jtlb_tag_idx[5:0]][95:48] = bus.jtlb_tag_din[95:48];
                    if (bus.jtlb_tag_wen[0]) sram[bus.jtlb_tag_idx[5:0]][47:0]  = bus.jtlb_tag_din[47:0];
                end
            end
        end
    end

    task automatic drive_idle();
        bus.lkup_req_vld = 1'b0;
        bus.lkup_idx     = '0;
        bus.wr_req_vld   = 1'b0;
        bus.wr_idx       = '0;
        bus.wr_way       = 1'b0;
        bus.wr_tag       = '0;
        bus.inv_all_req  = 1'b0;
    endtask

    task automatic do_lookup(input logic [5:0] i);
        @(negedge clk);
        drive_idle();
        bus.lkup_req_vld = 1'b1;
        bus.lkup_idx     = i;
        #1;
        n_checks++;
        if ({bus.lkup_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx} !== {1'b1, 1'b1, 3'b000, 3'b000, i}) begin
            n_fail++;
            $display("FAIL lookup_issue idx=%0d: rdy/cen/wen/idx got %b %b %b %0d", i,
                     bus.lkup_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx);
        end
        @(negedge clk);
        bus.lkup_req_vld = 1'b0;
        #1;
        n_checks++;
        if ({bus.lkup_rsp_vld, bus.lkup_rsp_tag, bus.lkup_rsp_victim} !== {1'b1, ref_mem[i], ref_mem[i][96]}) begin
            n_fail++;
            $display("FAIL lookup_rsp idx=%0d: vld=%b tag=%h victim=%b, expected vld=1 tag=%h victim=%b", i,
                     bus.lkup_rsp_vld, bus.lkup_rsp_tag, bus.lkup_rsp_victim, ref_mem[i], ref_mem[i][96]);
        end
    endtask

    task automatic do_write(input logic [5:0] i, input logic w, input logic [47:0] t);
        @(negedge clk);
        drive_idle();
        bus.wr_req_vld = 1'b1;
        bus.wr_idx     = i;
        bus.wr_way     = w;
        bus.wr_tag     = t;
        #1;
        n_checks++;
        if ({bus.wr_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.jtlb_tag_din}
            !== {1'b1, 1'b1, 1'b1, w, ~w, 3'b000, i, 1'b0, ~w, t, t}) begin
            n_fail++;
            $display("FAIL write_issue idx=%0d way=%b: rdy=%b cen=%b wen=%b idx=%0d din=%h", i, w,
                     bus.wr_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.jtlb_tag_din);
        end
        ref_write(i, w, t);
        @(negedge clk);
        bus.wr_req_vld = 1'b0;
        #1;
        n_checks++;
        if (bus.lkup_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_after_write: lkup_rsp_vld=%b, expected 0", bus.lkup_rsp_vld);
        end
    endtask

    // Sweep straight out of reset: idx 0..63, then DONE, then writes accepted
    task automatic test_inv_on_rst();
        for (int i = 0; i < 64; i++) begin
            #1;
            n_checks++;
            if ({bus.inv_busy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.jtlb_tag_din, bus.wr_req_rdy}
                !== {1'b1, 1'b1, 3'b111, 9'(i), 98'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL rst_sweep step %0d: busy=%b cen=%b wen=%b idx=%0d wr_rdy=%b", i,
                         bus.inv_busy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.wr_req_rdy);
            end
            ref_mem[i] = '0;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({bus.inv_done, bus.wr_req_rdy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_sweep_done: done=%b wr_rdy=%b, expected 1 0", bus.inv_done, bus.wr_req_rdy);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.inv_done, bus.inv_busy, bus.wr_req_rdy} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_sweep_idle: done=%b busy=%b wr_rdy=%b, expected 0 0 1",
                     bus.inv_done, bus.inv_busy, bus.wr_req_rdy);
        end
        drive_idle();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst_b            = 1'b0;
            bus.lkup_req_vld = 1'($urandom);
            bus.lkup_idx     = 6'($urandom);
            bus.wr_req_vld   = 1'($urandom);
            bus.wr_idx       = 6'($urandom);
            bus.inv_all_req  = 1'($urandom);
            #1;
            n_checks++;
            if ({bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.lkup_req_rdy, bus.wr_req_rdy,
                 bus.inv_busy, bus.inv_done, bus.lkup_rsp_vld} !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: cen=%b wen=%b lk_rdy=%b wr_rdy=%b busy=%b done=%b rsp=%b, expected all 0",
                         k, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.lkup_req_rdy, bus.wr_req_rdy,
                         bus.inv_busy, bus.inv_done, bus.lkup_rsp_vld);
            end
        end
        @(negedge clk);
        drive_idle();
        rst_b = 1'b1;
`ifdef JTLB_INV_ON_RST_EN
        bus.wr_req_vld = 1'b1;
        bus.wr_idx     = 6'($urandom);
        test_inv_on_rst();
`else
        #1;
        n_checks++;
        if ({bus.wr_req_rdy, bus.lkup_req_rdy, bus.inv_busy, bus.jtlb_tag_cen} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_release: wr_rdy=%b lk_rdy=%b busy=%b cen=%b, expected 1 1 0 0",
                     bus.wr_req_rdy, bus.lkup_req_rdy, bus.inv_busy, bus.jtlb_tag_cen);
        end
`endif
    endtask

    task automatic test_lookup();
        do_lookup(6'd5);
        do_lookup(6'd63);
        do_lookup(6'd0);
    endtask

    task automatic test_write();
        do_write(6'd12, 1'b1, 48'hABC);
        do_lookup(6'd12);
        n_checks++;
        if ({bus.lkup_rsp_victim, bus.lkup_rsp_tag[95:48]} !== {1'b0, 48'hABC}) begin
            n_fail++;
            $display("FAIL write_readback: victim=%b way1=%h, expected 0 abc",
                     bus.lkup_rsp_victim, bus.lkup_rsp_tag[95:48]);
        end
        do_write(6'd12, 1'b0, 48'h1234_5678_9ABC);
        do_lookup(6'd12);
    endtask

    task automatic test_back_to_back();
        logic [63:0] t;
        t = {$urandom, $urandom};
        @(negedge clk);
        drive_idle();
        bus.wr_req_vld   = 1'b1;
        bus.wr_idx       = 6'd40;
        bus.wr_way       = 1'b0;
        bus.wr_tag       = t[47:0];
        bus.lkup_req_vld = 1'b1;
        bus.lkup_idx     = 6'd40;
        #1;
        n_checks++;
        if ({bus.wr_req_rdy, bus.lkup_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx}
            !== {1'b1, 1'b0, 1'b1, 3'b101, 9'd40}) begin
            n_fail++;
            $display("FAIL collide_write: wr_rdy=%b lk_rdy=%b cen=%b wen=%b idx=%0d, expected 1 0 1 101 40",
                     bus.wr_req_rdy, bus.lkup_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx);
        end
        ref_write(6'd40, 1'b0, t[47:0]);
        @(negedge clk);
        bus.wr_req_vld = 1'b0;
        #1;
        n_checks++;
        if ({bus.lkup_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.lkup_rsp_vld}
            !== {1'b1, 1'b1, 3'b000, 9'd40, 1'b0}) begin
            n_fail++;
            $display("FAIL collide_lookup: lk_rdy=%b cen=%b wen=%b idx=%0d rsp=%b, expected 1 1 000 40 0",
                     bus.lkup_req_rdy, bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.lkup_rsp_vld);
        end
        @(negedge clk);
        bus.lkup_req_vld = 1'b0;
        #1;
        n_checks++;
        if ({bus.lkup_rsp_vld, bus.lkup_rsp_tag, bus.lkup_rsp_victim} !== {1'b1, ref_mem[40], 1'b1}) begin
            n_fail++;
            $display("FAIL collide_rsp: vld=%b tag=%h victim=%b, expected 1 %h 1",
                     bus.lkup_rsp_vld, bus.lkup_rsp_tag, bus.lkup_rsp_victim, ref_mem[40]);
        end
    endtask

    task automatic test_random();
        logic [63:0] t;
        for (int k = 0; k < 40; k++) begin
            t = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) do_write(6'($urandom_range(0, 7)), 1'($urandom), t[47:0]);
            else                           do_lookup(6'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_inv_sweep();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        drive_idle();
        bus.inv_all_req  = 1'b1;
        bus.wr_req_vld   = 1'b1;
        bus.wr_idx       = 6'd3;
        bus.lkup_req_vld = 1'b1;
        #1;
        n_checks++;
        if ({bus.jtlb_tag_cen, bus.wr_req_rdy, bus.lkup_req_rdy, bus.inv_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL inv_start: cen=%b wr_rdy=%b lk_rdy=%b busy=%b, expected 0 0 0 0",
                     bus.jtlb_tag_cen, bus.wr_req_rdy, bus.lkup_req_rdy, bus.inv_busy);
        end
        @(negedge clk);
        bus.inv_all_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            n_checks++;
            if ({bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.jtlb_tag_din, bus.inv_busy,
                 bus.inv_done, bus.wr_req_rdy, bus.lkup_req_rdy} !== {1'b1, 3'b111, 9'(i), 98'd0, 4'b1000}) begin
                n_fail++;
                $display("FAIL inv_step %0d: cen=%b wen=%b idx=%0d busy=%b done=%b wr_rdy=%b lk_rdy=%b din=%h", i,
                         bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx, bus.inv_busy, bus.inv_done,
                         bus.wr_req_rdy, bus.lkup_req_rdy, bus.jtlb_tag_din);
            end
            if (bus.inv_done === 1'b1) done_cnt++;
            ref_mem[i]      = '0;
            bus.inv_all_req = 1'($urandom);
            @(negedge clk);
        end
        #1;
        if (bus.inv_done === 1'b1) done_cnt++;
        n_checks++;
        if ({bus.inv_done, bus.inv_busy, bus.jtlb_tag_cen, bus.wr_req_rdy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL inv_done_cycle: done=%b busy=%b cen=%b wr_rdy=%b, expected 1 1 0 0",
                     bus.inv_done, bus.inv_busy, bus.jtlb_tag_cen, bus.wr_req_rdy);
        end
        drive_idle();
        @(negedge clk);
        #1;
        if (bus.inv_done === 1'b1) done_cnt++;
        n_checks++;
        if ({bus.inv_busy, bus.wr_req_rdy, done_cnt} !== {1'b0, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL inv_end: busy=%b wr_rdy=%b done_pulses=%0d, expected 0 1 1",
                     bus.inv_busy, bus.wr_req_rdy, done_cnt);
        end
        for (int k = 0; k < 4; k++) do_lookup(6'($urandom));
        do_lookup(6'd12);
        do_lookup(6'd40);
    endtask

    task automatic test_reset_mid_sweep();
        logic [63:0] t;
        for (int k = 26; k < 36; k++) begin
            t = {$urandom, $urandom};
            do_write(6'(k), 1'($urandom), t[47:0]);
        end
        @(negedge clk);
        drive_idle();
        bus.inv_all_req = 1'b1;
        @(negedge clk);
        bus.inv_all_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ref_mem[i] = '0;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx} !== {1'b1, 3'b111, 9'd30}) begin
            n_fail++;
            $display("FAIL abort_at30: cen=%b wen=%b idx=%0d, expected 1 111 30",
                     bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.jtlb_tag_idx);
        end
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.inv_busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_in_reset: cen=%b wen=%b busy=%b, expected 0 000 0",
                     bus.jtlb_tag_cen, bus.jtlb_tag_wen, bus.inv_busy);
        end
        @(negedge clk);
        rst_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if ({bus.jtlb_tag_cen, bus.inv_busy, bus.inv_done, bus.wr_req_rdy} !== 4'b0001) begin
                n_fail++;
                $display("FAIL abort_after %0d: cen=%b busy=%b done=%b wr_rdy=%b, expected 0 0 0 1", k,
                         bus.jtlb_tag_cen, bus.inv_busy, bus.inv_done, bus.wr_req_rdy);
            end
            @(negedge clk);
        end
        for (int k = 28; k < 33; k++) do_lookup(6'(k));
    endtask

    task automatic test_rsp_suppress();
        @(negedge clk);
        drive_idle();
        bus.lkup_req_vld = 1'b1;
        bus.lkup_idx     = 6'($urandom);
        @(negedge clk);
        bus.lkup_req_vld = 1'b0;
        rst_b            = 1'b0;
        #1;
        n_checks++;
        if (bus.lkup_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_suppress_in_reset: lkup_rsp_vld=%b, expected 0", bus.lkup_rsp_vld);
        end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        n_checks++;
        if (bus.lkup_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_suppress_after: lkup_rsp_vld=%b, expected 0", bus.lkup_rsp_vld);
        end
        do_lookup(6'd5);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_row(i);
        drive_idle();
        test_reset();
        test_lookup();
        test_write();
        test_back_to_back();
        test_random();
        test_inv_sweep();
`ifndef JTLB_INV_ON_RST_EN
        test_reset_mid_sweep();
        test_rsp_suppress();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
